// File: rtl/fetch_pkg.sv
// fetch_pkg: types shared by the instruction fetch front end.
// Provides the FSM state enum, the queue entry struct and the word size.
package fetch_pkg;

    localparam int unsigned INSTR_BYTES = 4;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        FAULT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: FIFO of fq_entry_t between the ROM and decode.
// Ports: enq/enq_data in, deq pops head, flush empties (wins over enq),
// head/full/empty/count out. Storage is registered, head is mem[rd_ptr].
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       enq,
    input  fq_entry_t                  enq_data,
    input  logic                       deq,
    input  logic                       flush,
    output fq_entry_t                  head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    fq_entry_t      mem [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [CW-1:0]  cnt_q;
    logic           do_enq;
    logic           do_deq;

    assign full   = (cnt_q == CW'(DEPTH));
    assign empty  = (cnt_q == '0);
    assign count  = cnt_q;
    assign head   = mem[rd_ptr];

    assign do_deq = deq && !empty;
    // A full queue may still accept when the head leaves this cycle.
    assign do_enq = enq && !flush && (!full || do_deq);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt_q  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_enq) wr_ptr <= wr_ptr + 1'b1;
            if (do_deq) rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_enq, do_deq})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage is cleared on reset so head reads as zero while empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_enq) begin
            mem[wr_ptr] <= enq_data;
        end
    end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: PC, fetch FSM and fetch queue feeding decode.
// Ports: imem_addr/imem_rdata to ROM, redirect_valid/redirect_pc in,
// deq_valid/deq_ready/deq_instr/deq_pc to decode, fault/fault_pc, fq_count.
// Macro FETCH_BOUNDS_CHECK_EN enables PC legality checking and FAULT.
module instr_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned FQ_DEPTH  = 4,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    output logic [31:0]                   imem_addr,
    input  logic [31:0]                   imem_rdata,
    input  logic                          redirect_valid,
    input  logic [31:0]                   redirect_pc,
    input  logic                          deq_ready,
    output logic                          deq_valid,
    output logic [31:0]                   deq_instr,
    output logic [31:0]                   deq_pc,
    output logic                          fault,
    output logic [31:0]                   fault_pc,
    output logic [$clog2(FQ_DEPTH+1)-1:0] fq_count
);

    fetch_state_e state_q;
    fetch_state_e state_d;
    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic [31:0]  redir_pc;
    logic         illegal;
    logic         enq;
    logic         hs;
    logic         full;
    logic         empty;
    fq_entry_t    head;
    fq_entry_t    enq_data;

`ifdef FETCH_BOUNDS_CHECK_EN
    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

    logic        fault_ld;
    logic [31:0] fault_pc_q;

    assign illegal   = (pc_q[1:0] != 2'b00) || ((pc_q + 32'd3) >= MEM_LIMIT);
    assign redir_pc  = redirect_pc;
    assign imem_addr = pc_q;

    assign fault_ld  = !redirect_valid && (state_q == FETCH) && illegal;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) fault_pc_q <= '0;
        else if (fault_ld) fault_pc_q <= pc_q;
    end

    assign fault    = (state_q == FAULT);
    assign fault_pc = fault_pc_q;
`else
    localparam logic [31:0] MEM_MASK = 32'(MEM_BYTES - 1);

    // Without checking, targets are word-aligned and the ROM address wraps.
    assign illegal   = 1'b0;
    assign redir_pc  = redirect_pc & ~32'h3;
    assign imem_addr = pc_q & MEM_MASK;
    assign fault     = 1'b0;
    assign fault_pc  = '0;
`endif

    assign deq_valid = !empty;
    assign hs        = deq_valid && deq_ready;
    assign enq_data  = '{pc: pc_q, instr: imem_rdata};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        enq     = 1'b0;
        if (redirect_valid) begin
            state_d = FETCH;
            pc_d    = redir_pc;
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (illegal) begin
                        state_d = FAULT;
                    end else if (!full || hs) begin
                        enq  = 1'b1;
                        pc_d = pc_q + 32'(INSTR_BYTES);
                    end
                end
                FAULT: begin
                    state_d = FAULT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_fq (
        .clk      (clk),
        .reset_n  (reset_n),
        .enq      (enq),
        .enq_data (enq_data),
        .deq      (hs),
        .flush    (redirect_valid),
        .head     (head),
        .full     (full),
        .empty    (empty),
        .count    (fq_count)
    );

    assign deq_instr = head.instr;
    assign deq_pc    = head.pc;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl: scoreboard bench for instr_fetch_ctrl.
// Expected entries are queued by stimulus and popped at each handshake.
module tb_instr_fetch_ctrl;

    logic        clk;
    logic        reset_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        deq_ready;
    logic        deq_valid;
    logic [31:0] deq_instr;
    logic [31:0] deq_pc;
    logic        fault;
    logic [31:0] fault_pc;
    logic [2:0]  fq_count;

    logic [31:0] rom [256];
    logic [63:0] exp_q [$];
    logic [63:0] sb_e;
    int          checks;
    int          failures;
    int          hs_count;

    instr_fetch_ctrl #(
        .MEM_BYTES (1024),
        .FQ_DEPTH  (4),
        .RESET_PC  (32'h0)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .deq_ready      (deq_ready),
        .deq_valid      (deq_valid),
        .deq_instr      (deq_instr),
        .deq_pc         (deq_pc),
        .fault          (fault),
        .fault_pc       (fault_pc),
        .fq_count       (fq_count)
    );

    assign imem_rdata = rom[imem_addr[9:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc);
        logic [31:0] w;
        w = 32'h1000_0000 + 32'((pc >> 2) & 32'hff) * 32'd7;
        exp_q.push_back({pc, w});
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset_n && deq_valid && deq_ready) begin
            hs_count++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual_pc=%0h required=none",
                         deq_pc);
            end else begin
                sb_e = exp_q.pop_front();
                chk("sb_pc", deq_pc, sb_e[63:32]);
                chk("sb_instr", deq_instr, sb_e[31:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        checks         = 0;
        failures       = 0;
        hs_count       = 0;
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        deq_ready      = 1'b1;
        for (int i = 0; i < 256; i++)
            rom[i] = 32'h1000_0000 + 32'(i) * 32'd7;

        #12;
        chk("rst_valid", 32'(deq_valid), 32'd0);
        chk("rst_count", 32'(fq_count), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_pc", deq_pc, 32'h0);
        chk("rst_instr", deq_instr, 32'h0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_fault_pc", fault_pc, 32'h0);

        for (int i = 0; i < 8; i++) push(32'(i * 4));
        reset_n = 1'b1;
        step(1);
        chk("first_valid", 32'(deq_valid), 32'd1);
        chk("first_pc", deq_pc, 32'h0);
        step(8);
        chk("no_gaps", 32'(hs_count), 32'd8);

        deq_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        step(1);
        redirect_valid = 1'b0;
        chk("redir_empty", 32'(deq_valid), 32'd0);
        step(1);
        chk("redir_valid", 32'(deq_valid), 32'd1);
        chk("redir_pc", deq_pc, 32'h0);
        step(5);
        chk("stall_count", 32'(fq_count), 32'd4);
        chk("stall_pc", imem_addr, 32'd16);

        for (int i = 0; i < 5; i++) push(32'(i * 4));
        deq_ready = 1'b1;
        step(4);
        chk("full_count", 32'(fq_count), 32'd4);
        redirect_valid = 1'b1;
        redirect_pc    = 32'd32;
        step(1);
        redirect_valid = 1'b0;
        chk("flush_valid", 32'(deq_valid), 32'd0);
        chk("flush_count", 32'(fq_count), 32'd0);
        chk("flush_hs", 32'(hs_count), 32'd13);
        step(1);
        chk("flush_tgt", deq_pc, 32'd32);
        push(32'd32);
        push(32'd36);
        step(2);

`ifdef FETCH_BOUNDS_CHECK_EN
        push(32'd40);
        redirect_valid = 1'b1;
        redirect_pc    = 32'd1020;
        step(1);
        redirect_valid = 1'b0;
        push(32'd1020);
        step(2);
        chk("oob_fault", 32'(fault), 32'd1);
        chk("oob_fault_pc", fault_pc, 32'd1024);
        step(1);
        chk("oob_no_enq", 32'(fq_count), 32'd0);
        chk("oob_pc_hold", imem_addr, 32'd1024);
        redirect_valid = 1'b1;
        redirect_pc    = 32'd6;
        step(1);
        redirect_valid = 1'b0;
        chk("mis_clear", 32'(fault), 32'd0);
        step(1);
        chk("mis_fault", 32'(fault), 32'd1);
        chk("mis_fault_pc", fault_pc, 32'd6);
        redirect_valid = 1'b1;
        redirect_pc    = 32'd0;
        step(1);
        redirect_valid = 1'b0;
        chk("resume_clear", 32'(fault), 32'd0);
        chk("resume_fpc", fault_pc, 32'd6);
        push(32'd0);
        step(1);
        chk("resume_pc", deq_pc, 32'd0);
        step(1);
`else
        push(32'd40);
        redirect_valid = 1'b1;
        redirect_pc    = 32'd1022;
        step(1);
        redirect_valid = 1'b0;
        chk("align_addr", imem_addr, 32'd1020);
        push(32'd1020);
        push(32'd1024);
        step(1);
        chk("wrap_addr", imem_addr, 32'd0);
        chk("nofault", 32'(fault), 32'd0);
        step(2);
`endif

        deq_ready = 1'b0;
        step(2);
        chk("pre_rst_count", 32'(fq_count), 32'd3);
        #1;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", 32'(deq_valid), 32'd0);
        chk("arst_count", 32'(fq_count), 32'd0);
        chk("arst_addr", imem_addr, 32'h0);
        chk("arst_pc", deq_pc, 32'h0);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch_ctrl.md
# instr_fetch_ctrl

Fetch sequencer for the instruction ROM. It owns the PC, drives the ROM's combinational read address one word per cycle, and buffers fetched words with their PCs in a small fetch queue. It presents those entries to decode through a valid/ready handshake. It sits between the instruction ROM and the decode/rename front end, and accepts redirects from branch resolution and flush logic.

## Interface
Parameters:
- MEM_BYTES, 1024 — ROM size in bytes; power of two, > 4.
- FQ_DEPTH, 4 — fetch queue entries; power of two, ≥ 2.
- RESET_PC, 32'h0 — PC loaded on reset.

Ports:
- clk  in  1  — single clock; all state on posedge.
- reset_n  in  1  — asynchronous, active-low reset.
- imem_addr  out  32  — byte address to the ROM; equals the PC register.
- imem_rdata  in  32  — ROM instruction word; combinational from imem_addr.
- redirect_valid  in  1  — redirect or flush request.
- redirect_pc  in  32  — new fetch PC.
- deq_ready  in  1  — decode accepts the head entry.
- deq_valid  out  1  — head entry valid.
- deq_instr  out  32  — head instruction.
- deq_pc  out  32  — head PC.
- fault  out  1  — fetch halted on an illegal PC.
- fault_pc  out  32  — PC that faulted.
- fq_count  out  $clog2(FQ_DEPTH+1)  — occupied entries.

## Operation
- States: FETCH and FAULT. Reset enters FETCH.
- Redirect has priority in either state:
  - PC is loaded with redirect_pc.
  - Queue is flushed to count 0.
  - Nothing is enqueued that cycle.
  - State returns to FETCH, fault clears, fault_pc holds its value.
- In FETCH without a redirect:
  - If the PC is illegal (see Configuration): no enqueue, state goes to FAULT, fault_pc is loaded with the PC.
  - Else, if the queue is not full, or is full with deq_valid && deq_ready this cycle: enqueue {PC, imem_rdata} and set PC to PC+4.
  - Else: hold the PC.
- FAULT: no enqueue and the PC holds. Decode may still drain the existing entries. Only a redirect exits FAULT.
- Dequeue: when deq_valid && deq_ready, the head pops. Simultaneous enqueue and dequeue leaves the count unchanged.
- If a redirect coincides with a dequeue handshake, the handshake completes (decode consumed the entry) and the flush still clears the remaining entries.
- PC arithmetic is 32-bit unsigned and wraps modulo 2^32.
- Queue pointers are $clog2(FQ_DEPTH) bits and wrap naturally.

## Timing
- Reset values: PC = RESET_PC, imem_addr = RESET_PC, queue empty, deq_valid = 0, deq_instr = 0, deq_pc = 0, fault = 0, fault_pc = 0, fq_count = 0, state = FETCH.
- Mid-operation reset immediately restores all of the above.
- First instruction: deq_valid rises on the first posedge after reset_n deasserts, at deq_pc = RESET_PC.
- Throughput: one fetch per cycle while the queue is not full.
- Redirect asserted at edge N:
  - deq_valid is 0 after N.
  - Target entry is enqueued at N+1 and visible on deq at N+1 (deq_valid is 1 after edge N+1).
- Fault: fault rises on the edge after the illegal PC is presented. It falls on the edge that samples a redirect.
- deq_* outputs come from registered queue storage. There is no combinational path from imem_rdata to deq_*.

## Configuration
- FETCH_BOUNDS_CHECK_EN defined:
  - A PC is illegal if PC[1:0] != 0 or PC+3 >= MEM_BYTES (32-bit compare).
  - An illegal PC enters FAULT as described in Operation.
- FETCH_BOUNDS_CHECK_EN undefined:
  - No PC is illegal and FAULT is unreachable.
  - fault and fault_pc are tied to 0.
  - redirect_pc[1:0] is forced to 0 when loaded.
  - imem_addr = PC & (MEM_BYTES-1), so fetch wraps around the ROM.

## Structure
- Shared package fetch_pkg:
  - fetch_state_e {FETCH, FAULT}
  - fq_entry_t struct {pc[31:0], instr[31:0]}
  - INSTR_BYTES = 4
- Sub-module fetch_queue:
  - Parametric FIFO of fq_entry_t with enq, deq, flush, full, empty and count.
  - Flush has priority over enq.
- instr_fetch_ctrl holds the PC, the FSM and the legality check.

## Test plan
- Reset release, ROM preloaded with words W0..W7, deq_ready = 1 → deq_pc = 0,4,8,… with matching W, one per cycle, no gaps.
- deq_ready = 0 for 6 cycles → fq_count saturates at 4 and the PC holds at 16. deq_ready = 1 → entries drain in order at PCs 0..12, then fetch resumes at PC 16.
- Queue full, redirect_pc = 32 together with deq_ready = 1 → head popped, queue flushed, next deq_pc = 32 one cycle later.
- FETCH_BOUNDS_CHECK_EN defined, redirect_pc = 1020, then sequential fetch → 1020 delivered, fault = 1 with fault_pc = 1024, no further enqueue. Redirect to 0 → fault clears, fetch resumes at 0.
- FETCH_BOUNDS_CHECK_EN defined, redirect_pc = 6 → fault = 1, fault_pc = 6. Macro undefined, redirect_pc = 1022 → imem_addr = 1020, then wraps to 0.
- reset_n asserted mid-stream with 3 entries queued → deq_valid = 0, fq_count = 0 and imem_addr = RESET_PC immediately, without waiting for a clock edge.
